// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics types and pixel helpers used by the packer/unpacker family.
package gfx_pkg;

    localparam int MDW_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Out-of-range depths fall back to full 32-bit colour.
    function automatic logic [5:0] clamp_bpp(input logic [5:0] b);
        return (b == 6'd0 || b > 6'd32) ? 6'd32 : b;
    endfunction

    function automatic logic [31:0] pix_mask(input logic [5:0] b);
        return (b >= 6'd32) ? 32'hFFFF_FFFF : (32'd1 << b) - 32'd1;
    endfunction

endpackage

// File: rtl/gfx_pixel_extract.sv
// gfx_pixel_extract: picks one zero-extended pixel of i_bpp bits at bit offset i_ptr from a memory word.
module gfx_pixel_extract
    import gfx_pkg::*;
#(
    parameter int MDW = MDW_DEFAULT,
    parameter int PW  = $clog2(MDW) + 1
) (
    input  logic [MDW-1:0] i_wbuf,
    input  logic [PW-1:0]  i_ptr,
    input  logic [5:0]     i_bpp,
    output logic [31:0]    o_color
);

    assign o_color = 32'(i_wbuf >> i_ptr) & pix_mask(i_bpp);

endmodule

// File: rtl/gfx_pixel_unpacker.sv
// gfx_pixel_unpacker: splits MDW-wide memory words into a valid/ready stream of 32-bit colours.
module gfx_pixel_unpacker
    import gfx_pkg::*;
#(
    parameter int MDW = MDW_DEFAULT,
    parameter int CW  = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [5:0]     bpp_i,
    input  logic [7:0]     mb_i,
    input  logic [CW-1:0]  count_i,
    input  logic [MDW-1:0] word_i,
    input  logic           word_valid_i,
    output logic           word_ready_o,
    output logic [31:0]    color_o,
    output logic           color_valid_o,
    input  logic           color_ready_i,
    output logic           last_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam int PW = $clog2(MDW) + 1;

    state_t         r_state, w_next;
    logic [5:0]     r_bpp;
    logic [PW-1:0]  r_ptr;
    logic [CW-1:0]  r_rem;
    logic [MDW-1:0] r_wbuf;
    logic           r_skip;
    logic [31:0]    r_color;
    logic           r_valid, r_last;

    logic [5:0]     w_bpp_in;
    logic           w_first_fit, w_accept, w_out_free, w_load, w_last_pix, w_np_fits;
    logic [PW-1:0]  w_np;
    logic [31:0]    w_pix;

    assign w_bpp_in     = clamp_bpp(bpp_i);
    // mb can exceed MDW for narrow words, so the first-word fit test is done before ptr truncation.
    assign w_first_fit  = (10'(mb_i) + 10'(w_bpp_in)) <= 10'(MDW);
    assign word_ready_o = (r_state == ST_FETCH) && !abort_i;
    assign w_accept     = word_valid_i && word_ready_o;
    assign w_out_free   = !r_valid || color_ready_i;
    assign w_load       = (r_state == ST_EMIT) && (r_rem != '0) && w_out_free && !abort_i;
    assign w_last_pix   = r_rem == CW'(1);
    assign w_np         = r_ptr + PW'(r_bpp);
    assign w_np_fits    = ({1'b0, w_np} + (PW+1)'(r_bpp)) <= (PW+1)'(MDW);

    gfx_pixel_extract #(.MDW(MDW), .PW(PW)) u_extract (
        .i_wbuf  (r_wbuf),
        .i_ptr   (r_ptr),
        .i_bpp   (r_bpp),
        .o_color (w_pix)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_next = (count_i == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: if (w_accept && !r_skip) w_next = ST_EMIT;
            ST_EMIT: begin
                if (w_load && !w_last_pix && !w_np_fits) w_next = ST_FETCH;
                else if (r_rem == '0 && w_out_free) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (abort_i) w_next = ST_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_bpp   <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_wbuf  <= '0;
            r_skip  <= 1'b0;
            r_color <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start_i) begin
                r_bpp  <= w_bpp_in;
                r_ptr  <= w_first_fit ? PW'(mb_i) : '0;
                r_rem  <= count_i;
                r_skip <= !w_first_fit;
            end
            // A first word with no room for a pixel is consumed and discarded.
            if (w_accept) begin
                r_wbuf <= word_i;
                r_skip <= 1'b0;
            end
            if (w_load) begin
                r_color <= w_pix;
                r_rem   <= r_rem - CW'(1);
                r_ptr   <= (!w_last_pix && !w_np_fits) ? '0 : w_np;
            end
            if (abort_i) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_last  <= w_last_pix;
            end else if (color_ready_i) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign color_o       = r_color;
    assign color_valid_o = r_valid;
    assign last_o        = r_last;
    assign busy_o        = r_state != ST_IDLE;
    assign done_o        = (r_state == ST_DONE) && !abort_i;

endmodule

// File: tb/tb_gfx_pixel_unpacker.sv
// tb_gfx_pixel_unpacker: random-word runs of the unpacker checked against a bit-position reference model.
module tb_gfx_pixel_unpacker;

    localparam int MDW = 256;
    localparam int CW  = 16;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic [5:0]     bpp_i = '0;
    logic [7:0]     mb_i = '0;
    logic [CW-1:0]  count_i = '0;
    logic [MDW-1:0] word_i = '0;
    logic           word_valid_i = 1'b0;
    logic           word_ready_o;
    logic [31:0]    color_o;
    logic           color_valid_o;
    logic           color_ready_i = 1'b0;
    logic           last_o, busy_o, done_o;

    gfx_pixel_unpacker #(.MDW(MDW), .CW(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .bpp_i         (bpp_i),
        .mb_i          (mb_i),
        .count_i       (count_i),
        .word_i        (word_i),
        .word_valid_i  (word_valid_i),
        .word_ready_o  (word_ready_o),
        .color_o       (color_o),
        .color_valid_o (color_valid_o),
        .color_ready_i (color_ready_i),
        .last_o        (last_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    logic [MDW-1:0] wmem [64];
    int             n_cmp = 0, n_bad = 0;
    int             widx = 0, nfetch = 0, ndone = 0, rmode = 0, vmode = 0, stall_cnt = 0;
    int             exp_words = 0;
    bit             prev_stall = 0;
    logic [31:0]    prev_color = '0;
    logic           prev_last = 1'b0;
    logic [31:0]    got_c [$];
    bit             got_l [$];
    logic [31:0]    exp_c [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk bit positions word by word; a pixel that would cross the word end moves to bit 0 of the next word.
    function automatic void build_model(input int b, input int m, input int cnt);
        int             eb, pos, w;
        longint         mask;
        logic [MDW-1:0] sh;
        eb   = (b == 0 || b > 32) ? 32 : b;
        mask = (longint'(1) << eb) - 1;
        exp_c.delete();
        pos  = m;
        w    = 0;
        if (pos + eb > MDW) begin w = 1; pos = 0; end
        for (int i = 0; i < cnt; i++) begin
            if (pos + eb > MDW) begin w++; pos = 0; end
            sh = wmem[w] >> pos;
            exp_c.push_back(sh[31:0] & mask[31:0]);
            pos += eb;
        end
        exp_words = (cnt == 0) ? 0 : w + 1;
    endfunction

    task automatic fill_words();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < MDW / 32; j++)
                wmem[i][j*32 +: 32] = $urandom();
    endtask

    // One clock: drive handshake inputs on the falling edge, then observe what the next rising edge will commit.
    task automatic cycle();
        @(negedge clk_i);
        word_valid_i  = (vmode == 1) || (vmode == 2 && $urandom_range(0, 1) == 1);
        word_i        = wmem[widx & 63];
        color_ready_i = (rmode == 0) || (rmode == 1 && $urandom_range(0, 3) != 0) || (rmode == 2 && stall_cnt >= 5);
        #1;
        if (prev_stall && !abort_i) begin
            check("stall_hold_color", color_o, prev_color);
            check("stall_hold_last", last_o, prev_last);
            check("stall_hold_valid", color_valid_o, 1);
        end
        if (word_valid_i && word_ready_o) begin widx++; nfetch++; end
        if (color_valid_o && color_ready_i) begin
            got_c.push_back(color_o);
            got_l.push_back(last_o);
        end
        if (rmode == 2 && color_valid_o && stall_cnt < 5) stall_cnt++;
        if (done_o) ndone++;
        prev_stall = color_valid_o && !color_ready_i;
        prev_color = color_o;
        prev_last  = last_o;
    endtask

    task automatic run_job(input string tag, input int b, input int m, input int cnt,
                           input int rm, input int vm, input bit keep);
        int n;
        if (!keep) fill_words();
        build_model(b, m, cnt);
        widx = 0; nfetch = 0; ndone = 0; stall_cnt = 0; prev_stall = 0;
        rmode = rm; vmode = vm;
        got_c.delete(); got_l.delete();
        bpp_i = 6'(b); mb_i = 8'(m); count_i = CW'(cnt);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        check({tag, " ready_after_start"}, word_ready_o, 1);
        for (int k = 0; k < 3000 && ndone == 0; k++) cycle();
        check({tag, " done_pulses"}, ndone, 1);
        check({tag, " pixel_count"}, got_c.size(), cnt);
        check({tag, " words_fetched"}, nfetch, exp_words);
        n = (got_c.size() < cnt) ? got_c.size() : cnt;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s pix%0d", tag, i), got_c[i], exp_c[i]);
            check($sformatf("%s last%0d", tag, i), got_l[i], (i == cnt - 1));
        end
        cycle();
        check({tag, " idle_after_done"}, busy_o, 0);
        check({tag, " single_done"}, ndone, 1);
    endtask

    initial begin
        logic [MDW-1:0] w1;
        fill_words();
        repeat (3) cycle();
        check("reset word_ready", word_ready_o, 0);
        check("reset color_valid", color_valid_o, 0);
        check("reset last", last_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset color", color_o, 0);
        rst_i = 1'b0;
        cycle();

        fill_words();
        wmem[0][31:0] = 32'h4433_2211;
        run_job("t1", 8, 0, 4, 0, 1, 1);
        if (got_c.size() == 4) begin
            check("t1 first", got_c[0], 32'h11);
            check("t1 final", got_c[3], 32'h44);
        end

        run_job("t2", 24, 0, 11, 0, 1, 0);
        check("t2 fetches", nfetch, 2);

        run_job("t3", 16, 0, 3, 2, 1, 0);

        bpp_i = 6'd8; mb_i = '0; count_i = '0;
        ndone = 0; nfetch = 0; vmode = 1; rmode = 0; prev_stall = 0;
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        check("t4 busy", busy_o, 1);
        check("t4 done", done_o, 1);
        check("t4 no_ready", word_ready_o, 0);
        cycle();
        check("t4 busy_clear", busy_o, 0);
        check("t4 done_clear", done_o, 0);
        check("t4 fetches", nfetch, 0);
        check("t4 done_count", ndone, 1);

        run_job("t5", 0, 248, 3, 0, 1, 0);
        w1 = wmem[1];
        if (got_c.size() > 0) check("t5 pix0_word1", got_c[0], w1[31:0]);

        fill_words();
        widx = 0; ndone = 0; rmode = 0; vmode = 1; prev_stall = 0;
        got_c.delete(); got_l.delete();
        bpp_i = 6'd4; mb_i = '0; count_i = CW'(200);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        for (int k = 0; k < 50 && got_c.size() < 3; k++) cycle();
        check("t6 emitting", color_valid_o, 1);
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        check("t6 abort_valid", color_valid_o, 0);
        check("t6 abort_idle", busy_o, 0);
        repeat (3) cycle();
        check("t6 abort_no_done", ndone, 0);
        check("t6 abort_still_idle", busy_o, 0);

        vmode = 0;
        bpp_i = 6'd8; count_i = CW'(5);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        check("t6 in_fetch", word_ready_o, 1);
        rst_i = 1'b1;
        #1;
        check("t6 rst_word_ready", word_ready_o, 0);
        check("t6 rst_busy", busy_o, 0);
        check("t6 rst_valid", color_valid_o, 0);
        check("t6 rst_done", done_o, 0);
        check("t6 rst_color", color_o, 0);
        cycle();
        rst_i = 1'b0;
        prev_stall = 0;
        check("t6 rst_no_done", ndone, 0);
        run_job("t6 restart", 8, 3, 20, 1, 2, 0);

        for (int r = 0; r < 8; r++)
            run_job($sformatf("rnd%0d", r), $urandom_range(0, 40), $urandom_range(0, 255),
                    $urandom_range(1, 40), 1, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
